// File: rtl/gbc_gamepak_phy_target.sv
// gbc_gamepak_phy_target: Wishbone classic target producing Game Boy cartridge pin timing.
// Define GBC_PAK_PHI_EN to generate PakPhi and align each pin cycle to PHI-low.
module gbc_gamepak_phy_target #(
   parameter int SetupTicks     = 20,
   parameter int StrobeTicks    = 100,
   parameter int HoldTicks      = 20,
   parameter int ResetHoldTicks = 1000,
   parameter int PhiHalfTicks   = 100
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        WbCyc,
   input  logic        WbStb,
   input  logic        WbWe,
   input  logic [15:0] WbAdr,
   input  logic [7:0]  WbDatI,
   output logic [7:0]  WbDatO,
   output logic        WbAck,
   output logic        WbStall,
   output logic [15:0] PakAddr,
   output logic [7:0]  PakDOut,
   output logic        PakDOE,
   input  logic [7:0]  PakDIn,
   output logic        PakRdN,
   output logic        PakWrN,
   output logic        PakCsN,
   output logic        PakResetN,
   output logic        PakPhi
);
   localparam int CW = 10;

   if (SetupTicks < 1 || SetupTicks > 255 || StrobeTicks < 1 || StrobeTicks > 1023 ||
       HoldTicks < 1 || HoldTicks > 255 || ResetHoldTicks < 1 || ResetHoldTicks > 65535 ||
       PhiHalfTicks < 1) begin : g_bad_param
      $error("gbc_gamepak_phy_target: tick parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK, FAST} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [15:0]    rst_cnt;
   logic [15:0]    addr;
   logic [7:0]     wdat, rdat;
   logic           we, abort, req, accept, fast, pin, phi_wait;

   assign req     = WbCyc & WbStb;
   assign fast    = WbAdr[15:14] == 2'b11;
   assign WbStall = !Reset && (state != IDLE || !PakResetN || phi_wait);
   assign accept  = req && !WbStall && PakResetN;
   assign pin     = state == SETUP || state == STROBE || state == HOLD;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (accept) begin
            state_nxt = fast ? FAST : SETUP;
            cnt_nxt   = CW'(SetupTicks - 1);
         end
         SETUP: if (cnt == '0) begin
            state_nxt = STROBE;
            cnt_nxt   = CW'(StrobeTicks - 1);
         end else cnt_nxt = cnt - 1'b1;
         STROBE: if (cnt == '0) begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(HoldTicks - 1);
         end else cnt_nxt = cnt - 1'b1;
         HOLD: if (cnt == '0) begin
            state_nxt = ACK;
            cnt_nxt   = '0;
         end else cnt_nxt = cnt - 1'b1;
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rst_cnt   <= '0;
         PakResetN <= 1'b0;
         addr      <= '0;
         wdat      <= '0;
         rdat      <= 8'hFF;
         we        <= 1'b0;
         abort     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!PakResetN) begin
            rst_cnt   <= rst_cnt + 1'b1;
            PakResetN <= rst_cnt == 16'(ResetHoldTicks - 1);
         end
         // Out-of-range accesses leave the address and data pins untouched.
         if (accept) begin
            we    <= WbWe;
            abort <= 1'b0;
            if (!fast) begin
               addr <= WbAdr;
               wdat <= WbDatI;
            end
         end else if (!req) abort <= 1'b1;
         if (state == STROBE && cnt == '0) rdat <= PakDIn;
      end
   end

   assign PakAddr = addr;
   assign PakDOut = wdat;
   assign PakDOE  = we && pin;
   assign PakCsN  = !(pin && addr[15:13] == 3'b101);
   assign PakRdN  = !(!we && (state == SETUP || state == STROBE));
   assign PakWrN  = !(we && state == STROBE);
   assign WbAck   = (state == ACK || state == FAST) && !abort;
   assign WbDatO  = (state == ACK && !we) ? rdat : 8'hFF;

`ifdef GBC_PAK_PHI_EN
   localparam int PW = $clog2(PhiHalfTicks + 1);
   logic [PW-1:0] phi_cnt;
   // Also wait when PHI is about to rise so SETUP always begins in PHI-low.
   assign phi_wait = PakPhi || phi_cnt == PW'(PhiHalfTicks - 1);
   always_ff @(posedge Clk) begin
      if (Reset || !PakResetN) begin
         phi_cnt <= '0;
         PakPhi  <= 1'b0;
      end else if (phi_cnt == PW'(PhiHalfTicks - 1)) begin
         phi_cnt <= '0;
         PakPhi  <= !PakPhi;
      end else phi_cnt <= phi_cnt + 1'b1;
   end
`else
   assign phi_wait = 1'b0;
   assign PakPhi   = 1'b0;
`endif
endmodule

// File: tb/tb_gbc_gamepak_phy_target.sv
// tb_gbc_gamepak_phy_target: directed and randomized checks against a timeline model of the pin cycle.
module tb_gbc_gamepak_phy_target;
   localparam int S = 20, T = 100, H = 20, P = S + T + H, RH = 1000;
`ifdef GBC_PAK_PHI_EN
   localparam bit PHI_EN = 1'b1;
`else
   localparam bit PHI_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset, WbCyc, WbStb, WbWe;
   logic [15:0] WbAdr;
   logic [7:0]  WbDatI, WbDatO, PakDOut, PakDIn;
   logic        WbAck, WbStall, PakDOE, PakRdN, PakWrN, PakCsN, PakResetN, PakPhi;
   logic [15:0] PakAddr;
   logic [15:0] last_addr = 16'h0000;
   int          passed = 0, total = 0, fails = 0;

   always #5 Clk = ~Clk;

   gbc_gamepak_phy_target dut (
      .Clk(Clk), .Reset(Reset), .WbCyc(WbCyc), .WbStb(WbStb), .WbWe(WbWe),
      .WbAdr(WbAdr), .WbDatI(WbDatI), .WbDatO(WbDatO), .WbAck(WbAck), .WbStall(WbStall),
      .PakAddr(PakAddr), .PakDOut(PakDOut), .PakDOE(PakDOE), .PakDIn(PakDIn),
      .PakRdN(PakRdN), .PakWrN(PakWrN), .PakCsN(PakCsN), .PakResetN(PakResetN), .PakPhi(PakPhi)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // One Wishbone transaction checked cycle by cycle against the phase timeline.
   task automatic txn(input logic [15:0] a, input logic w, input logic [7:0] d,
                      input int abort_at, input int exp_wait, input int din);
      int         waited, p;
      bit         fast, ab;
      logic [7:0] din_exp;
      logic [4:0] e;
      WbCyc = 1'b1; WbStb = 1'b1; WbWe = w; WbAdr = a; WbDatI = d;
      PakDIn = 8'($urandom);
      waited = 0;
      while ((WbStall || !PakResetN) && waited < 3000) begin
         step();
         waited++;
      end
      if (waited >= 3000) begin
         chk("accept_timeout", waited, 0);
         WbCyc = 1'b0; WbStb = 1'b0;
         return;
      end
      if (exp_wait >= 0 && !PHI_EN) chk("accept_wait", waited, exp_wait);
      step();
      fast    = a >= 16'hC000;
      p       = fast ? 0 : P;
      ab      = abort_at >= 0 && abort_at < p;
      din_exp = 8'hFF;
      for (int k = 0; k <= p + 1; k++) begin
         if (k < p) e = {1'b0, !(!w && k < S + T), !(w && k >= S && k < S + T),
                         !(a >= 16'hA000 && a < 16'hC000), w};
         else if (k == p) e = {!ab, 4'b1110};
         else e = 5'b01110;
         chk("ctl", {WbAck, PakRdN, PakWrN, PakCsN, PakDOE}, e);
         if (k <= p || !PHI_EN) chk("stall", WbStall, k <= p);
         chk("addr", PakAddr, fast ? last_addr : a);
         if (k < p && w) chk("dout", PakDOut, d);
         if (k == p && !ab) chk("dato", WbDatO, (w || fast) ? 8'hFF : din_exp);
         PakDIn = din >= 0 ? din[7:0] : 8'($urandom);
         if (k == S + T - 1) din_exp = PakDIn;
         if (k == abort_at || k == p) begin
            WbCyc = 1'b0; WbStb = 1'b0;
         end
         if (k <= p) step();
      end
      if (!fast) last_addr = a;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] ra;
      Reset = 1'b1; WbCyc = 1'b0; WbStb = 1'b0; WbWe = 1'b0;
      WbAdr = '0; WbDatI = '0; PakDIn = '0;
      repeat (5) step();
      chk("rst_ack", WbAck, 0);
      chk("rst_stall", WbStall, 0);
      chk("rst_dato", WbDatO, 8'hFF);
      chk("rst_addr", PakAddr, 0);
      chk("rst_dout", {PakDOut, PakDOE}, 0);
      chk("rst_strobes", {PakRdN, PakWrN, PakCsN}, 3'b111);
      chk("rst_pins", {PakResetN, PakPhi}, 0);
      Reset = 1'b0;
      repeat (500) step();
      chk("hold_resetn", PakResetN, 0);
      chk("hold_stall", WbStall, 1);
      // Request issued at cycle 500 of the reset hold; read at 0x0150 with PakDIn=0x3C.
      txn(16'h0150, 1'b0, 8'h00, -1, RH - 500, 8'h3C);
      txn(16'hA123, 1'b1, 8'h5A, -1, 0, -1);
      txn(16'hC000, 1'b0, 8'h00, -1, 0, -1);
      txn(16'hFFFF, 1'b1, 8'h77, -1, 0, -1);
      txn(16'h2000, 1'b1, 8'h11, 10, 0, -1);
      txn(16'h0001, 1'b0, 8'h00, -1, 0, -1);
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 3))
            0: ra = 16'($urandom_range(0, 16'h9FFF));
            1: ra = 16'($urandom_range(16'hA000, 16'hBFFF));
            2: ra = 16'($urandom_range(16'hC000, 16'hFFFF));
            default: ra = 16'($urandom);
         endcase
         txn(ra, 1'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 150)) : -1, 0, -1);
      end
      // Reset during STROBE cycle 50 of a write.
      WbCyc = 1'b1; WbStb = 1'b1; WbWe = 1'b1; WbAdr = 16'h4000; WbDatI = 8'hA5;
      n = 0;
      while (WbStall && n < 3000) begin
         step();
         n++;
      end
      step();
      repeat (S + 50) step();
      chk("mid_wrn", {PakWrN, PakDOE}, 2'b01);
      Reset = 1'b1;
      step();
      chk("abort_pins", {WbAck, PakRdN, PakWrN, PakCsN, PakDOE}, 5'b01110);
      WbCyc = 1'b0; WbStb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_noack", {WbAck, PakResetN, PakPhi}, 0);
      end
      Reset = 1'b0;
      n = 0;
      while (!PakResetN && n < 3000) begin
         chk("rehold_noack", WbAck, 0);
         step();
         n++;
      end
      chk("rehold_len", n, RH);
      if (PHI_EN) begin
         n = 0;
         while (!PakPhi && n < 1000) begin
            step();
            n++;
         end
         chk("phi_first_half", n, 100);
         n = 0;
         while (PakPhi && n < 1000) begin
            step();
            n++;
         end
         while (!PakPhi && n < 1000) begin
            step();
            n++;
         end
         chk("phi_period", n, 200);
      end
      txn(16'hB000, 1'b0, 8'h00, -1, -1, -1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
